// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State encoding, port indices and legal memory-latency range.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 8;
  // Wide enough to hold MEM_LAT_MAX-1.
  localparam int unsigned CNT_W = 3;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_LDR) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin select: on a tie the port that was not
// served last wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      idx = ~last;
    end else begin
      idx = req[PORT_LDR];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the CPU (port 0) and the loader (port 1).
// One latched transaction at a time: IDLE -> ISSUE -> WAIT x MEM_LAT -> RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 12,
  parameter int unsigned DW      = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be within 1..8");
  end

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic              port_q, we_q, last_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q, rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pick_valid, pick_idx;

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (cnt_q == '0) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Command latch, round-robin history, latency counter and read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q  <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= PORT_LDR;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == StIdle && pick_valid) begin
        port_q  <= pick_idx;
        we_q    <= we[pick_idx];
        addr_q  <= pick_idx ? addr1 : addr0;
        wdata_q <= pick_idx ? wdata1 : wdata0;
        last_q  <= pick_idx;
      end
      if (state_q == StIssue) begin
        cnt_q <= CntLoad;
      end else if (state_q == StWait && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == StWait && cnt_q == '0 && !we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    gnt       = busy ? port_onehot(port_q) : 2'b00;
    ack       = (state_q == StResp) ? port_onehot(port_q) : 2'b00;
    mem_en    = (state_q == StIssue);
    mem_we    = mem_en & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
  end

endmodule
